// File: rtl/multi_channel_delay_line.sv
// Delays N_CHANNELS audio streams through one shared single-port circular buffer
// and produces a saturated mix of the delayed channels.
//
// state  | meaning
// IDLE   | waiting for a frame strobe; inputs latched on strobe
// WR     | write current channel's sample at {ch, wr_ptr}
// RD     | read {ch, wr_ptr - delay}
// CAP    | capture read data (or 0 while not enough history)
// DONE   | publish outputs and mix, advance wr_ptr and fill counter
module multi_channel_delay_line #(
    parameter int  N_CHANNELS = 3,
    parameter int  WIDTH      = 16,
    parameter int  MAX_DELAY  = 4096,
    localparam int DELAY_BITS = $clog2(MAX_DELAY)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           sample_valid_in,
    input  logic [N_CHANNELS*WIDTH-1:0]    samples_in,
    input  logic [N_CHANNELS*DELAY_BITS-1:0] delays_in,
    output logic [N_CHANNELS*WIDTH-1:0]    samples_out,
    output logic [WIDTH-1:0]               mix_out,
    output logic                           valid_out,
    output logic                           busy_out,
    output logic                           overrun_out
);

    localparam int CH_BITS = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int SUM_W   = WIDTH + $clog2(N_CHANNELS) + 1;
    localparam int DEPTH   = N_CHANNELS * MAX_DELAY;
    localparam int ADDR_W  = CH_BITS + DELAY_BITS;

    localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [CH_BITS-1:0]             ch_q, ch_d;
    logic [DELAY_BITS-1:0]          wr_ptr_q, wr_ptr_d;
    logic [DELAY_BITS-1:0]          frames_q, frames_d;
    logic [WIDTH-1:0]               samp_q [N_CHANNELS];
    logic [WIDTH-1:0]               samp_d [N_CHANNELS];
    logic [DELAY_BITS-1:0]          dly_q [N_CHANNELS];
    logic [DELAY_BITS-1:0]          dly_d [N_CHANNELS];
    logic signed [WIDTH-1:0]        out_q [N_CHANNELS];
    logic signed [WIDTH-1:0]        out_d [N_CHANNELS];
    logic [N_CHANNELS*WIDTH-1:0]    samples_out_q, samples_out_d;
    logic [WIDTH-1:0]               mix_q, mix_d;
    logic                           valid_q, valid_d;
    logic                           overrun_q, overrun_d;

    logic [WIDTH-1:0]               mem [DEPTH];
    logic [WIDTH-1:0]               rd_data_q;
    logic                           mem_we;
    logic [ADDR_W-1:0]              mem_addr;
    logic [WIDTH-1:0]               mem_wdata;
    logic [DELAY_BITS-1:0]          rd_ptr;

    logic signed [SUM_W-1:0]        sum;
    logic [WIDTH-1:0]               mix_sat;

    // Pointer subtraction wraps within the channel's own region.
    assign rd_ptr = wr_ptr_q - dly_q[ch_q];

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_data_q <= mem[mem_addr];
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            sum = sum + SUM_W'(out_q[k]);
        end
        if (sum > SUM_MAX) begin
            mix_sat = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sum < SUM_MIN) begin
            mix_sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            mix_sat = sum[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        wr_ptr_d      = wr_ptr_q;
        frames_d      = frames_q;
        samp_d        = samp_q;
        dly_d         = dly_q;
        out_d         = out_q;
        samples_out_d = samples_out_q;
        mix_d         = mix_q;
        valid_d       = 1'b0;
        overrun_d     = overrun_q | (sample_valid_in && (state_q != S_IDLE));
        mem_we        = 1'b0;
        mem_addr      = {ch_q, wr_ptr_q};
        mem_wdata     = samp_q[ch_q];

        case (state_q)
            S_IDLE: begin
                if (sample_valid_in) begin
                    for (int k = 0; k < N_CHANNELS; k++) begin
                        samp_d[k] = samples_in[k*WIDTH +: WIDTH];
                        dly_d[k]  = delays_in[k*DELAY_BITS +: DELAY_BITS];
                    end
                    ch_d    = '0;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                mem_we  = 1'b1;
                state_d = S_RD;
            end
            S_RD: begin
                mem_addr = {ch_q, rd_ptr};
                state_d  = S_CAP;
            end
            S_CAP: begin
                // Until enough frames exist, the slot holds stale data from before reset.
                if (dly_q[ch_q] > frames_q) begin
                    out_d[ch_q] = '0;
                end else begin
                    out_d[ch_q] = rd_data_q;
                end
                if (ch_q == CH_BITS'(N_CHANNELS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_WR;
                end
            end
            S_DONE: begin
                for (int k = 0; k < N_CHANNELS; k++) begin
                    samples_out_d[k*WIDTH +: WIDTH] = out_q[k];
                end
                mix_d    = mix_sat;
                valid_d  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (frames_q != {DELAY_BITS{1'b1}}) begin
                    frames_d = frames_q + 1'b1;
                end
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            ch_q          <= '0;
            wr_ptr_q      <= '0;
            frames_q      <= '0;
            samp_q        <= '{default: '0};
            dly_q         <= '{default: '0};
            out_q         <= '{default: '0};
            samples_out_q <= '0;
            mix_q         <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            wr_ptr_q      <= wr_ptr_d;
            frames_q      <= frames_d;
            samp_q        <= samp_d;
            dly_q         <= dly_d;
            out_q         <= out_d;
            samples_out_q <= samples_out_d;
            mix_q         <= mix_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign samples_out = samples_out_q;
    assign mix_out     = mix_q;
    assign valid_out   = valid_q;
    assign busy_out    = (state_q != S_IDLE);
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_multi_channel_delay_line.sv
// Bench for multi_channel_delay_line: vector table, randomized frames against a
// frame-history reference model, and hand sequences for overrun and reset cases.
module tb_multi_channel_delay_line;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int MD = 64;
    localparam int DB = 6;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              sample_valid_in;
    logic [N*W-1:0]    samples_in;
    logic [N*DB-1:0]   delays_in;
    logic [N*W-1:0]    samples_out;
    logic [W-1:0]      mix_out;
    logic              valid_out;
    logic              busy_out;
    logic              overrun_out;

    multi_channel_delay_line #(
        .N_CHANNELS(N),
        .WIDTH     (W),
        .MAX_DELAY (MD)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .sample_valid_in(sample_valid_in),
        .samples_in     (samples_in),
        .delays_in      (delays_in),
        .samples_out    (samples_out),
        .mix_out        (mix_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Every frame accepted since the last reset, oldest first.
    logic [N*W-1:0] hist [$];

    typedef struct {
        logic [N*W-1:0]  s;
        logic [N*DB-1:0] d;
        logic [N*W-1:0]  es;
        logic [W-1:0]    em;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack3(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [N*DB-1:0] pack_d(input int a, input int b, input int c);
        return {6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic model_expect(input logic [N*W-1:0] s, input logic [N*DB-1:0] d,
                                output logic [N*W-1:0] es, output logic [W-1:0] em);
        int n, fw, dk, sum;
        logic [W-1:0] v;
        hist.push_back(s);
        n   = hist.size() - 1;
        fw  = (n > MD - 1) ? MD - 1 : n;
        sum = 0;
        es  = '0;
        for (int k = 0; k < N; k++) begin
            dk = int'(d[k*DB +: DB]);
            if (dk > fw) v = '0;
            else         v = hist[n - dk][k*W +: W];
            es[k*W +: W] = v;
            sum += int'($signed(v));
        end
        if (sum > 32767)       sum = 32767;
        else if (sum < -32768) sum = -32768;
        em = 16'(sum);
    endtask

    task automatic do_reset();
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        hist.delete();
    endtask

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic run_frame(input logic [N*W-1:0] s, input logic [N*DB-1:0] d, input int period,
                             output logic [N*W-1:0] gs, output logic [W-1:0] gm);
        logic [N*W-1:0] es;
        logic [W-1:0]   em;
        int lat, busy_cnt;
        samples_in      = s;
        delays_in       = d;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        model_expect(s, d, es, em);
        busy_cnt = busy_out ? 1 : 0;
        lat = 0;
        gs  = '0;
        gm  = '0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk_in);
            #1;
            if (valid_out) begin
                lat = c;
                gs  = samples_out;
                gm  = mix_out;
            end else if (busy_out) begin
                busy_cnt++;
            end
        end
        check("latency", lat, 10);
        check("busy_len", busy_cnt, 10);
        for (int k = 0; k < N; k++) begin
            check($sformatf("ch%0d", k), gs[k*W +: W], es[k*W +: W]);
        end
        check("mix", gm, em);
        for (int c = 0; c < period - lat - 1; c++) begin
            @(posedge clk_in);
            #1;
            if (c == 0) check("valid_pulse", valid_out, 1'b0);
        end
        check("hold", samples_out, es);
    endtask

    // Frame strobe followed by a second strobe sampled 'gap' edges after the first.
    task automatic strobe_pair(input int gap, input logic [N*W-1:0] s, input logic [N*DB-1:0] d,
                               input logic [N*W-1:0] s2, output int nvalid, output int lat,
                               output logic [N*W-1:0] gs, output logic [W-1:0] gm);
        samples_in      = s;
        delays_in       = d;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        nvalid = 0;
        lat    = 0;
        gs     = '0;
        gm     = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_in);
            #1;
            if (valid_out) begin
                nvalid++;
                if (lat == 0) begin
                    lat = c;
                    gs  = samples_out;
                    gm  = mix_out;
                end
            end
            if (c == gap - 1) begin
                sample_valid_in = 1'b1;
                samples_in      = s2;
            end else begin
                sample_valid_in = 1'b0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N*W-1:0] gs, es;
        logic [W-1:0]   gm, em;
        logic [W-1:0]   in0 [200];
        int nvalid, lat, d1, d2;

        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        samples_in      = '0;
        delays_in       = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_samples", samples_out, 0);
        check("rst_mix", mix_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_overrun", overrun_out, 0);
        rst_in = 1'b0;
        hist.delete();

        // Pass-through vectors: ramp frames, then saturation corners.
        for (int i = 0; i < 5; i++) begin
            tbl[i].s  = pack3(i, -i, 100);
            tbl[i].d  = '0;
            tbl[i].es = pack3(i, -i, 100);
            tbl[i].em = 16'd100;
        end
        tbl[5] = '{pack3('h7000, 'h7000, 'h7000), '0, pack3('h7000, 'h7000, 'h7000), 16'h7FFF};
        tbl[6] = '{pack3('h9000, 'h9000, 'h9000), '0, pack3('h9000, 'h9000, 'h9000), 16'h8000};
        tbl[7] = '{pack3('h4000, 'h4000, 'hC000), '0, pack3('h4000, 'h4000, 'hC000), 16'h4000};
        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].s, tbl[i].d, 50, gs, gm);
            check($sformatf("tbl%0d_samples", i), gs, tbl[i].es);
            check($sformatf("tbl%0d_mix", i), gm, tbl[i].em);
        end

        // Ramp with delays {5,1,63}.
        do_reset();
        for (int n = 0; n < 70; n++) begin
            run_frame(pack3(n, n, n), pack_d(5, 1, 63), 50, gs, gm);
            if (n == 4)  check("ramp_ch0_f4", gs[15:0], 0);
            if (n == 10) check("ramp_ch0_f10", gs[15:0], 5);
            if (n == 3)  check("ramp_ch1_f3", gs[31:16], 2);
            if (n == 62) check("ramp_ch2_f62", gs[47:32], 0);
            if (n == 64) check("ramp_ch2_f64", gs[47:32], 1);
        end

        // Randomized frames across several pointer wraps, ch0 fixed at delay 7.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            logic [N*W-1:0] s;
            s      = {16'($urandom), 16'($urandom), 16'($urandom)};
            in0[n] = s[15:0];
            d1     = int'($urandom_range(0, 63));
            d2     = int'($urandom_range(0, 63));
            run_frame(s, pack_d(7, d1, d2), 20, gs, gm);
            check("rand_ch0_d7", gs[15:0], (n >= 7) ? in0[n - 7] : 16'h0);
        end

        // Second strobe 4 cycles into a frame.
        do_reset();
        strobe_pair(4, pack3(11, 22, 33), '0, pack3(44, 55, 66), nvalid, lat, gs, gm);
        check("ovr_nvalid", nvalid, 1);
        check("ovr_latency", lat, 10);
        check("ovr_samples", gs, pack3(11, 22, 33));
        check("ovr_mix", gm, 66);
        check("ovr_flag", overrun_out, 1);
        model_expect(pack3(11, 22, 33), '0, es, em);
        run_frame(pack3(1, 2, 3), pack_d(1, 1, 0), 50, gs, gm);
        check("ovr_next_ch0", gs[15:0], 11);
        check("ovr_next_ch2", gs[47:32], 3);
        check("ovr_sticky", overrun_out, 1);

        // Strobe landing on the DONE cycle.
        do_reset();
        check("ovr_cleared", overrun_out, 0);
        strobe_pair(10, pack3(5, 6, 7), '0, pack3(8, 9, 10), nvalid, lat, gs, gm);
        check("done_nvalid", nvalid, 1);
        check("done_samples", gs, pack3(5, 6, 7));
        check("done_flag", overrun_out, 1);

        // Fill memory, then reset mid-frame; stale data must not leak out.
        do_reset();
        for (int n = 0; n < 66; n++) begin
            run_frame(pack3(n + 1000, n + 2000, n + 3000), '0, 15, gs, gm);
        end
        samples_in      = pack3(7777, 7777, 7777);
        delays_in       = '0;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        repeat (4) begin
            @(posedge clk_in);
            #1;
        end
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        hist.delete();
        nvalid = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk_in);
            #1;
            if (valid_out) nvalid++;
        end
        check("abort_nvalid", nvalid, 0);
        check("abort_samples", samples_out, 0);
        check("abort_mix", mix_out, 0);
        check("abort_busy", busy_out, 0);
        for (int n = 0; n < 6; n++) begin
            run_frame(pack3(n + 1, n + 1, n + 1), pack_d(3, 3, 3), 50, gs, gm);
            check("post_rst_ch0", gs[15:0], (n < 3) ? 16'h0 : 16'(n - 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
